// File: rtl/instr_decode.sv
// RV32I decode stage: 32x32 register file, control decode, immediates, ID/EX register.
// Optional macro WB_BYPASS_EN makes WB writes visible to same-cycle reads (write-first).
module instr_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_if_id,
  input  logic [31:0] PC_if_id,
  input  logic        branch_mem_id,
  input  logic        reg_write_wb_id,
  input  logic [4:0]  rd_wb_id,
  input  logic [31:0] rd_data_wb_id,
  output logic [31:0] PC_id_ex,
  output logic [31:0] rs1_data_id_ex,
  output logic [31:0] rs2_data_id_ex,
  output logic [31:0] imm_id_ex,
  output logic [4:0]  rs1_id_ex,
  output logic [4:0]  rs2_id_ex,
  output logic [4:0]  rd_id_ex,
  output logic [2:0]  funct3_id_ex,
  output logic [3:0]  alu_op_id_ex,
  output logic        alu_src_a_pc_id_ex,
  output logic        alu_src_b_imm_id_ex,
  output logic        mem_read_id_ex,
  output logic        mem_write_id_ex,
  output logic        reg_write_id_ex,
  output logic        branch_id_ex,
  output logic        jump_id_ex,
  output logic [1:0]  wb_sel_id_ex,
  output logic        illegal_id_ex
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  logic [31:0] rf_q [32];

  logic [6:0]  opcode;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign opcode  = instr_if_id[6:0];
  assign rd_idx  = instr_if_id[11:7];
  assign funct3  = instr_if_id[14:12];
  assign rs1_idx = instr_if_id[19:15];
  assign rs2_idx = instr_if_id[24:20];

  assign imm_i = {{20{instr_if_id[31]}}, instr_if_id[31:20]};
  assign imm_s = {{20{instr_if_id[31]}}, instr_if_id[31:25], instr_if_id[11:7]};
  assign imm_b = {{19{instr_if_id[31]}}, instr_if_id[31], instr_if_id[7],
                  instr_if_id[30:25], instr_if_id[11:8], 1'b0};
  assign imm_u = {instr_if_id[31:12], 12'b0};
  assign imm_j = {{11{instr_if_id[31]}}, instr_if_id[31], instr_if_id[19:12],
                  instr_if_id[20], instr_if_id[30:21], 1'b0};

`ifdef WB_BYPASS_EN
  logic wb_hit;
  assign wb_hit  = reg_write_wb_id && (rd_wb_id != 5'd0);
  assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 :
                   (wb_hit && rd_wb_id == rs1_idx) ? rd_data_wb_id : rf_q[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? 32'd0 :
                   (wb_hit && rd_wb_id == rs2_idx) ? rd_data_wb_id : rf_q[rs2_idx];
`else
  assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 : rf_q[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? 32'd0 : rf_q[rs2_idx];
`endif

  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_from_funct = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_from_funct = ALU_SLL;
      3'd2:    alu_from_funct = ALU_SLT;
      3'd3:    alu_from_funct = ALU_SLTU;
      3'd4:    alu_from_funct = ALU_XOR;
      3'd5:    alu_from_funct = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_from_funct = ALU_OR;
      default: alu_from_funct = ALU_AND;
    endcase
  endfunction

  logic [31:0] imm_d;
  logic [3:0]  alu_op_d;
  logic [1:0]  wb_sel_d;
  logic        src_a_d, src_b_d, mem_read_d, mem_write_d, reg_write_d;
  logic        branch_d, jump_d, illegal_d;

  always_comb begin
    imm_d       = 32'd0;
    alu_op_d    = ALU_ADD;
    wb_sel_d    = 2'b00;
    src_a_d     = 1'b0;
    src_b_d     = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    illegal_d   = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_op_d    = alu_from_funct(funct3, instr_if_id[30]);
        reg_write_d = 1'b1;
      end
      OPC_OPIMM: begin
        // Bit 30 of an I-immediate only selects arithmetic shift for SRAI.
        alu_op_d    = alu_from_funct(funct3, (funct3 == 3'd5) && instr_if_id[30]);
        imm_d       = imm_i;
        src_b_d     = 1'b1;
        reg_write_d = 1'b1;
      end
      OPC_LOAD: begin
        imm_d = imm_i; src_b_d = 1'b1; mem_read_d = 1'b1;
        reg_write_d = 1'b1; wb_sel_d = 2'b01;
      end
      OPC_STORE: begin
        imm_d = imm_s; src_b_d = 1'b1; mem_write_d = 1'b1;
      end
      OPC_BRANCH: begin
        imm_d = imm_b; alu_op_d = ALU_SUB; branch_d = 1'b1;
      end
      OPC_LUI: begin
        imm_d = imm_u; alu_op_d = ALU_PASSB; src_b_d = 1'b1; reg_write_d = 1'b1;
      end
      OPC_AUIPC: begin
        imm_d = imm_u; src_a_d = 1'b1; src_b_d = 1'b1; reg_write_d = 1'b1;
      end
      OPC_JAL: begin
        imm_d = imm_j; src_a_d = 1'b1; src_b_d = 1'b1; jump_d = 1'b1;
        reg_write_d = 1'b1; wb_sel_d = 2'b10;
      end
      OPC_JALR: begin
        imm_d = imm_i; src_b_d = 1'b1; jump_d = 1'b1;
        reg_write_d = 1'b1; wb_sel_d = 2'b10;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (reg_write_wb_id && (rd_wb_id != 5'd0)) begin
      rf_q[rd_wb_id] <= rd_data_wb_id;
    end
  end

  // A flush turns the ID/EX register into an all-zero bubble, same as reset.
  always_ff @(posedge clk) begin
    if (!rst || branch_mem_id) begin
      PC_id_ex            <= 32'd0;
      rs1_data_id_ex      <= 32'd0;
      rs2_data_id_ex      <= 32'd0;
      imm_id_ex           <= 32'd0;
      rs1_id_ex           <= 5'd0;
      rs2_id_ex           <= 5'd0;
      rd_id_ex            <= 5'd0;
      funct3_id_ex        <= 3'd0;
      alu_op_id_ex        <= 4'd0;
      alu_src_a_pc_id_ex  <= 1'b0;
      alu_src_b_imm_id_ex <= 1'b0;
      mem_read_id_ex      <= 1'b0;
      mem_write_id_ex     <= 1'b0;
      reg_write_id_ex     <= 1'b0;
      branch_id_ex        <= 1'b0;
      jump_id_ex          <= 1'b0;
      wb_sel_id_ex        <= 2'b00;
      illegal_id_ex       <= 1'b0;
    end else begin
      PC_id_ex            <= PC_if_id;
      rs1_data_id_ex      <= rs1_val;
      rs2_data_id_ex      <= rs2_val;
      imm_id_ex           <= imm_d;
      rs1_id_ex           <= rs1_idx;
      rs2_id_ex           <= rs2_idx;
      rd_id_ex            <= rd_idx;
      funct3_id_ex        <= funct3;
      alu_op_id_ex        <= alu_op_d;
      alu_src_a_pc_id_ex  <= src_a_d;
      alu_src_b_imm_id_ex <= src_b_d;
      mem_read_id_ex      <= mem_read_d;
      mem_write_id_ex     <= mem_write_d;
      reg_write_id_ex     <= reg_write_d;
      branch_id_ex        <= branch_d;
      jump_id_ex          <= jump_d;
      wb_sel_id_ex        <= wb_sel_d;
      illegal_id_ex       <= illegal_d;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Directed-vector bench for instr_decode: decode table plus reset/WB/flush/bypass sequences.
module tb_instr_decode;

  logic        clk;
  logic        rst;
  logic [31:0] instr_if_id, PC_if_id, rd_data_wb_id;
  logic        branch_mem_id, reg_write_wb_id;
  logic [4:0]  rd_wb_id;
  logic [31:0] PC_id_ex, rs1_data_id_ex, rs2_data_id_ex, imm_id_ex;
  logic [4:0]  rs1_id_ex, rs2_id_ex, rd_id_ex;
  logic [2:0]  funct3_id_ex;
  logic [3:0]  alu_op_id_ex;
  logic        alu_src_a_pc_id_ex, alu_src_b_imm_id_ex, mem_read_id_ex, mem_write_id_ex;
  logic        reg_write_id_ex, branch_id_ex, jump_id_ex, illegal_id_ex;
  logic [1:0]  wb_sel_id_ex;

  instr_decode dut (
    .clk(clk), .rst(rst), .instr_if_id(instr_if_id), .PC_if_id(PC_if_id),
    .branch_mem_id(branch_mem_id), .reg_write_wb_id(reg_write_wb_id),
    .rd_wb_id(rd_wb_id), .rd_data_wb_id(rd_data_wb_id),
    .PC_id_ex(PC_id_ex), .rs1_data_id_ex(rs1_data_id_ex), .rs2_data_id_ex(rs2_data_id_ex),
    .imm_id_ex(imm_id_ex), .rs1_id_ex(rs1_id_ex), .rs2_id_ex(rs2_id_ex), .rd_id_ex(rd_id_ex),
    .funct3_id_ex(funct3_id_ex), .alu_op_id_ex(alu_op_id_ex),
    .alu_src_a_pc_id_ex(alu_src_a_pc_id_ex), .alu_src_b_imm_id_ex(alu_src_b_imm_id_ex),
    .mem_read_id_ex(mem_read_id_ex), .mem_write_id_ex(mem_write_id_ex),
    .reg_write_id_ex(reg_write_id_ex), .branch_id_ex(branch_id_ex), .jump_id_ex(jump_id_ex),
    .wb_sel_id_ex(wb_sel_id_ex), .illegal_id_ex(illegal_id_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order: {src_a, src_b, mem_read, mem_write, reg_write, branch, jump, wb_sel[1:0], illegal}
  localparam logic [9:0] SA = 10'b1000000000, SB = 10'b0100000000, MR = 10'b0010000000;
  localparam logic [9:0] MW = 10'b0001000000, RW = 10'b0000100000, BR = 10'b0000010000;
  localparam logic [9:0] JP = 10'b0000001000, WPC = 10'b0000000100, WLD = 10'b0000000010;
  localparam logic [9:0] ILL = 10'b0000000001;

  logic [9:0] ctrl_act;
  assign ctrl_act = {alu_src_a_pc_id_ex, alu_src_b_imm_id_ex, mem_read_id_ex, mem_write_id_ex,
                     reg_write_id_ex, branch_id_ex, jump_id_ex, wb_sel_id_ex, illegal_id_ex};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [9:0]  ctrl;
  } vec_t;

  vec_t        vecs[20];
  logic [31:0] ref_rf[32];
  int          errs = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input logic [31:0] pc, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [3:0] alu, input logic [9:0] ctrl);
    chk({tag, ".pc"},   PC_id_ex, pc);
    chk({tag, ".rs1d"}, rs1_data_id_ex, d1);
    chk({tag, ".rs2d"}, rs2_data_id_ex, d2);
    chk({tag, ".imm"},  imm_id_ex, imm);
    chk({tag, ".idx"},  {17'd0, rs1_id_ex, rs2_id_ex, rd_id_ex}, {17'd0, r1, r2, rd});
    chk({tag, ".f3"},   {29'd0, funct3_id_ex}, {29'd0, f3});
    chk({tag, ".alu"},  {28'd0, alu_op_id_ex}, {28'd0, alu});
    chk({tag, ".ctrl"}, {22'd0, ctrl_act}, {22'd0, ctrl});
  endtask

  task automatic cyc(input logic [31:0] ins, input logic [31:0] pc, input logic br,
                     input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                     input logic rs);
    @(negedge clk);
    instr_if_id = ins; PC_if_id = pc; branch_mem_id = br;
    reg_write_wb_id = we; rd_wb_id = wrd; rd_data_wb_id = wd; rst = rs;
    @(posedge clk);
    #1;
    if (!rs) begin
      for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    end else if (we && wrd != 5'd0) begin
      ref_rf[wrd] = wd;
    end
  endtask

  initial begin
    logic [31:0] ins, exp_d1, exp_d2, byp1, byp2;

    vecs[0]  = '{32'h000283B3, 32'h1000, 32'h00000000, 4'd0,  RW};
    vecs[1]  = '{32'hFFF00093, 32'h1004, 32'hFFFFFFFF, 4'd0,  SB | RW};
    vecs[2]  = '{32'hFE000EE3, 32'h1008, 32'hFFFFFFFC, 4'd1,  BR};
    vecs[3]  = '{32'h00612423, 32'h100C, 32'h00000008, 4'd0,  SB | MW};
    vecs[4]  = '{32'hFE112E23, 32'h1010, 32'hFFFFFFFC, 4'd0,  SB | MW};
    vecs[5]  = '{32'h8001A503, 32'h1014, 32'hFFFFF800, 4'd0,  SB | MR | RW | WLD};
    vecs[6]  = '{32'h12345237, 32'h1018, 32'h12345000, 4'd10, SB | RW};
    vecs[7]  = '{32'hFFFFF297, 32'h101C, 32'hFFFFF000, 4'd0,  SA | SB | RW};
    vecs[8]  = '{32'hFF9FF0EF, 32'h1020, 32'hFFFFFFF8, 4'd0,  SA | SB | JP | RW | WPC};
    vecs[9]  = '{32'h00008067, 32'h1024, 32'h00000000, 4'd0,  SB | JP | RW | WPC};
    vecs[10] = '{32'h4033D313, 32'h1028, 32'h00000403, 4'd7,  SB | RW};
    vecs[11] = '{32'h0033D313, 32'h102C, 32'h00000003, 4'd6,  SB | RW};
    vecs[12] = '{32'h40008093, 32'h1030, 32'h00000400, 4'd0,  SB | RW};
    vecs[13] = '{32'h402081B3, 32'h1034, 32'h00000000, 4'd1,  RW};
    vecs[14] = '{32'h4020D1B3, 32'h1038, 32'h00000000, 4'd7,  RW};
    vecs[15] = '{32'h002091B3, 32'h103C, 32'h00000000, 4'd2,  RW};
    vecs[16] = '{32'h0020A1B3, 32'h1040, 32'h00000000, 4'd3,  RW};
    vecs[17] = '{32'h0020B1B3, 32'h1044, 32'h00000000, 4'd4,  RW};
    vecs[18] = '{32'h0020F1B3, 32'h1048, 32'h00000000, 4'd9,  RW};
    vecs[19] = '{32'h00A3A5FF, 32'h104C, 32'h00000000, 4'd0,  ILL};

    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    rst = 1'b0; instr_if_id = 32'd0; PC_if_id = 32'd0; branch_mem_id = 1'b0;
    reg_write_wb_id = 1'b0; rd_wb_id = 5'd0; rd_data_wb_id = 32'd0;

    // Reset held two cycles with a live instruction at the input
    cyc(32'h000283B3, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    cyc(32'h000283B3, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk_dec("reset", 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 4'd0, 10'd0);
    cyc(32'h000283B3, 32'h104, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk_dec("post_reset", 32'h104, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0, 5'd7, 3'd0, 4'd0, RW);

    // Writeback then read
    cyc(32'h00000000, 32'h108, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    cyc(32'h000283B3, 32'h10C, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk_dec("wb_read", 32'h10C, 32'hDEADBEEF, 32'd0, 32'd0, 5'd5, 5'd0, 5'd7, 3'd0, 4'd0, RW);

    // x0 ignores writes, also when written in the same cycle it is read
    cyc(32'h00000000, 32'h110, 1'b0, 1'b1, 5'd0, 32'h00001234, 1'b1);
    cyc(32'h00000033, 32'h114, 1'b0, 1'b1, 5'd0, 32'h00005678, 1'b1);
    chk("x0_rs1d", rs1_data_id_ex, 32'd0);
    chk("x0_rs2d", rs2_data_id_ex, 32'd0);
    cyc(32'h00000033, 32'h118, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("x0_rs1d_later", rs1_data_id_ex, 32'd0);

    // Register contents used by the decode table
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 5'd1,  32'h11111111, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 5'd2,  32'h22222222, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 5'd3,  32'h33333333, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 5'd7,  32'h77777777, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 5'd10, 32'hAAAAAAAA, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 5'd31, 32'hFFFF0031, 1'b1);

    for (int i = 0; i < 20; i++) begin
      ins    = vecs[i].instr;
      exp_d1 = ref_rf[ins[19:15]];
      exp_d2 = ref_rf[ins[24:20]];
      cyc(ins, vecs[i].pc, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      chk_dec($sformatf("vec%0d", i), vecs[i].pc, exp_d1, exp_d2, vecs[i].imm,
              ins[19:15], ins[24:20], ins[11:7], ins[14:12], vecs[i].alu, vecs[i].ctrl);
    end

    // Flush beats decode; the concurrent WB write still lands
    cyc(32'h000283B3, 32'h200, 1'b1, 1'b1, 5'd9, 32'h99990009, 1'b1);
    chk_dec("flush", 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 4'd0, 10'd0);
    cyc(32'h000483B3, 32'h204, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk_dec("after_flush", 32'h204, 32'h99990009, 32'd0, 32'd0, 5'd9, 5'd0, 5'd7, 3'd0, 4'd0, RW);
    cyc(32'hFFF00093, 32'h208, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    chk_dec("flush_imm", 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 4'd0, 10'd0);
    cyc(32'h0000007F, 32'h20C, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk_dec("illegal", 32'h20C, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 4'd0, ILL);

    // Same-cycle WB write and read of the same register
`ifdef WB_BYPASS_EN
    byp1 = 32'h00000055; byp2 = 32'h00000066;
`else
    byp1 = 32'h00000011; byp2 = 32'h00000055;
`endif
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 5'd3, 32'h00000011, 1'b1);
    cyc(32'h000183B3, 32'h300, 1'b0, 1'b1, 5'd3, 32'h00000055, 1'b1);
    chk("bypass_rs1", rs1_data_id_ex, byp1);
    chk("bypass_rs1_other", rs2_data_id_ex, 32'd0);
    cyc(32'h003003B3, 32'h304, 1'b0, 1'b1, 5'd3, 32'h00000066, 1'b1);
    chk("bypass_rs2", rs2_data_id_ex, byp2);
    chk("bypass_rs2_other", rs1_data_id_ex, 32'd0);
    cyc(32'h000183B3, 32'h308, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("bypass_settled", rs1_data_id_ex, 32'h00000066);
    cyc(32'h002081B3, 32'h30C, 1'b0, 1'b1, 5'd4, 32'h00000044, 1'b1);
    chk("indep_rs1", rs1_data_id_ex, 32'h11111111);
    chk("indep_rs2", rs2_data_id_ex, 32'h22222222);

    // Reset mid-stream outranks flush and WB write, and clears the register file
    cyc(32'h000283B3, 32'h400, 1'b1, 1'b1, 5'd5, 32'h0000CAFE, 1'b0);
    chk_dec("mid_reset", 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 4'd0, 10'd0);
    cyc(32'h002081B3, 32'h404, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk_dec("after_reset", 32'h404, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, 4'd0, RW);
    cyc(32'h000283B3, 32'h408, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("after_reset_x5", rs1_data_id_ex, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
# instr_decode

Instruction-decode stage of the RV32I pipeline: sits directly downstream of instruction fetch and consumes its IF/ID outputs (instruction word, PC). It holds the 32×32 architectural register file, decodes control, and builds sign-extended immediates. Results are registered into the ID/EX pipeline register. A taken branch from MEM flushes the stage, and the WB stage writes back through a dedicated port.

## Interface
- No parameters; XLEN fixed at 32, 32 registers.
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset (asserted when 0)
- instr_if_id  input  32  instruction word from fetch
- PC_if_id  input  32  PC of instr_if_id
- branch_mem_id  input  1  taken branch/jump resolved in MEM; flushes ID/EX
- reg_write_wb_id  input  1  WB write enable
- rd_wb_id  input  5  WB destination register
- rd_data_wb_id  input  32  WB write data
- PC_id_ex  output  32  registered PC
- rs1_data_id_ex, rs2_data_id_ex  output  32 each  registered operand values
- imm_id_ex  output  32  sign-extended immediate
- rs1_id_ex, rs2_id_ex, rd_id_ex  output  5 each  register indices
- funct3_id_ex  output  3  funct3 field (branch/load/store width)
- alu_op_id_ex  output  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10
- alu_src_a_pc_id_ex  output  1  ALU A = PC (AUIPC, JAL)
- alu_src_b_imm_id_ex  output  1  ALU B = immediate
- mem_read_id_ex, mem_write_id_ex, reg_write_id_ex, branch_id_ex, jump_id_ex  output  1 each  control
- wb_sel_id_ex  output  2  00 ALU, 01 load data, 10 PC+4
- illegal_id_ex  output  1  unsupported opcode seen

## Operation
- Register file: x0 reads 0 and ignores writes. Write occurs on a rising edge when reg_write_wb_id=1 and rd_wb_id≠0. Reads are combinational, indexed by instr_if_id[19:15] and [24:20].
- Decode by opcode:
  - OP: alu_op from funct3 and funct7[5]; SUB/SRA when funct7[5]=1.
  - OP-IMM: I-immediate; funct7[5] is honoured only for SRAI.
  - LOAD: I-immediate, mem_read=1, wb_sel=01.
  - STORE: S-immediate, mem_write=1, reg_write=0.
  - BRANCH: B-immediate, branch=1, alu_op SUB.
  - LUI: U-immediate, alu_op PASSB.
  - AUIPC: U-immediate, src_a=PC, ADD.
  - JAL: J-immediate, src_a=PC, jump=1, wb_sel=10.
  - JALR: I-immediate, jump=1, wb_sel=10.
- Immediates: I/S/B/U/J per RV32I. B and J have bit 0 = 0. U is imm[31:12]<<12. All others are sign-extended from instr[31].
- Unknown opcode: all control 0 (bubble), illegal=1. Index and data fields are still registered.
- Flush: if branch_mem_id=1 at an edge, the ID/EX register loads a bubble (all control, indices, illegal and imm = 0). The input instruction is discarded. PC and data are don't-care but driven to 0.
- Flush has priority over decode. WB writes still happen during a flush.

## Timing
- Latency: instruction presented in cycle N appears on *_id_ex after edge N+1 (one register stage).
- No stall input; a new instruction is accepted every cycle.
- Reset (rst=0 at an edge): every output goes to 0, equivalent to a bubble. All 32 registers are cleared to 0. This takes priority over flush and WB write.
- Reset mid-stream: the instruction in ID is lost. The first valid decode appears one edge after rst returns to 1.
- Same-cycle WB write and read of the same register: see Configuration. Different registers are independent.
- A WB write with rd_wb_id=0 has no effect; x0 reads return 0 in all modes.

## Configuration
- WB_BYPASS_EN defined: write-first register file. If reg_write_wb_id=1, rd_wb_id≠0 and rd_wb_id matches rs1/rs2, rd_data_wb_id is forwarded into rs*_data_id_ex at the same edge.
- WB_BYPASS_EN undefined: read-before-write; the old register value is captured, and the hazard unit must cover the 3-cycle WB→ID distance.

## Test plan
- Reset: rst=0 for 2 cycles with instr_if_id=0x000283B3 → all *_id_ex outputs 0. After release, reading x5 gives rs1_data 0.
- Writeback then read: write x5=0xDEADBEEF, next cycle instr 0x000283B3 (add x7,x5,x0) → rs1_data 0xDEADBEEF, rd 7, alu_op 0, reg_write 1, wb_sel 00.
- x0 protection: write rd_wb_id=0 with data 0x00001234, then instr 0x00000033 → rs1_data and rs2_data both 0.
- Immediates:
  - 0xFFF00093 (addi x1,x0,-1) → imm 0xFFFFFFFF, alu_src_b_imm 1.
  - 0xFE000EE3 (beq x0,x0,-4) → imm 0xFFFFFFFC, branch 1, alu_op 1, reg_write 0.
- Flush and illegal:
  - branch_mem_id=1 with 0x000283B3 at input → next outputs all-zero bubble.
  - instr 0x0000007F → all control 0, illegal 1.
- Bypass: write x3=0x00000055 and read x3 in the same cycle, x3 previously 0x11 → rs1_data 0x55 with WB_BYPASS_EN, 0x11 without it.
